// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] to the round core.
// Optional round index output enabled by defining MSG_SCHED_ROUND_IDX_EN.
module sha256_msg_schedule (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] word_in,
    input  logic        word_in_valid,
    output logic        word_in_ready,
    output logic [31:0] w_out,
    output logic        w_out_valid,
    input  logic        w_out_ready,
`ifdef MSG_SCHED_ROUND_IDX_EN
    output logic [5:0]  round_idx,
`endif
    output logic        block_done
);

    localparam int LOAD_WORDS = 16;
    localparam int NUM_ROUNDS = 64;

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  rnd_cnt_q, rnd_cnt_d;
    logic [31:0] win_q [LOAD_WORDS];
    logic [31:0] win_d [LOAD_WORDS];
    logic        done_q, done_d;
    logic [31:0] expand;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]}
             ^ {x[17:0], x[31:18]}
             ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]}
             ^ {x[18:0], x[31:19]}
             ^ {10'd0, x[31:10]};
    endfunction

    assign expand = sig1(win_q[14]) + win_q[9]
                  + sig0(win_q[1]) + win_q[0];

    // Next-state: load words into the window, then shift/expand per emitted word
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        rnd_cnt_d  = rnd_cnt_q;
        done_d     = 1'b0;
        for (int i = 0; i < LOAD_WORDS; i++) begin
            win_d[i] = win_q[i];
        end
        unique case (state_q)
            LOAD: begin
                if (word_in_valid) begin
                    win_d[load_cnt_q] = word_in;
                    load_cnt_d        = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'(LOAD_WORDS - 1)) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (w_out_ready) begin
                    for (int i = 0; i < LOAD_WORDS - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[LOAD_WORDS-1] = expand;
                    rnd_cnt_d           = rnd_cnt_q + 6'd1;
                    if (rnd_cnt_q == 6'(NUM_ROUNDS - 1)) begin
                        done_d  = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            rnd_cnt_q  <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < LOAD_WORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            rnd_cnt_q  <= rnd_cnt_d;
            done_q     <= done_d;
            for (int i = 0; i < LOAD_WORDS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign word_in_ready = (state_q == LOAD);
    assign w_out_valid   = (state_q == EMIT);
    assign w_out         = win_q[0];
    assign block_done    = done_q;

`ifdef MSG_SCHED_ROUND_IDX_EN
    assign round_idx = rnd_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: scoreboard of expected W words,
// checked by a monitor whenever an output transfer is pending.
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t [16];

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_in_valid = 1'b0;
    logic        word_in_ready;
    logic [31:0] w_out;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic        block_done;
`ifdef MSG_SCHED_ROUND_IDX_EN
    logic [5:0]  round_idx;
`endif

    sha256_msg_schedule dut (
        .clock         (clock),
        .reset         (reset),
        .word_in       (word_in),
        .word_in_valid (word_in_valid),
        .word_in_ready (word_in_ready),
        .w_out         (w_out),
        .w_out_valid   (w_out_valid),
        .w_out_ready   (w_out_ready),
`ifdef MSG_SCHED_ROUND_IDX_EN
        .round_idx     (round_idx),
`endif
        .block_done    (block_done)
    );

    always #5 clock = ~clock;

    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mon_idx = 0;
    bit          mon_en = 1'b0;
    bit          done_exp = 1'b0;
    int          emit_cyc = 0;
    int          exp_emit_cyc = 64;
    bit          hold_v = 1'b0;
    logic [31:0] hold_w = '0;
    bit          bp_mode = 1'b0;
    blk_t        abc_blk;
    blk_t        blk2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sg0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sg1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference schedule built from the textbook recurrence on a flat array
    task automatic push_block(input blk_t m, input bit is_abc);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++)
            w[t] = sg1(w[t-2]) + w[t-7] + sg0(w[t-15]) + w[t-16];
        if (is_abc) begin
            w[16] = 32'h61626380;
            w[17] = 32'h000F0000;
            w[63] = 32'h12B1EDEB;
        end
        for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
    endtask

    // Monitor: checks each pending output transfer, stalls and done pulse
    always @(negedge clock) begin
        if (mon_en) begin
            if (block_done || done_exp)
                chk("block_done", {31'd0, block_done}, {31'd0, done_exp});
            done_exp = 1'b0;
            if (w_out_valid) begin
                emit_cyc++;
                if (hold_v) chk("stall_hold", w_out, hold_w);
                if (w_out_ready) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h want none", w_out);
                    end else begin
                        chk($sformatf("W%0d", mon_idx), w_out, exp_q.pop_front());
                    end
`ifdef MSG_SCHED_ROUND_IDX_EN
                    chk("round_idx", {26'd0, round_idx}, 32'(mon_idx));
`endif
                    if (mon_idx == 63) begin
                        chk("emit_cycles", 32'(emit_cyc), 32'(exp_emit_cyc));
                        emit_cyc = 0;
                        done_exp = 1'b1;
                        mon_idx  = 0;
                    end else begin
                        mon_idx++;
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_w = w_out;
                end
            end
        end
    end

    // Backpressure driver: ready alternates starting low in the first EMIT cycle
    always @(posedge clock) begin
        #1;
        if (bp_mode) w_out_ready = w_out_valid ? ~w_out_ready : 1'b1;
    end

    task automatic load_block(input blk_t m, input bit is_abc, input int gap_at);
        push_block(m, is_abc);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                word_in_valid = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("gap_ready", {31'd0, word_in_ready}, 32'd1);
                    chk("gap_no_emit", {31'd0, w_out_valid}, 32'd0);
                    @(posedge clock);
                    #1;
                end
            end
            word_in_valid = 1'b1;
            word_in       = m[i];
            @(negedge clock);
            if (i == 0 || i == 15)
                chk("load_ready", {31'd0, word_in_ready}, 32'd1);
            @(posedge clock);
            #1;
        end
        word_in_valid = 1'b0;
        word_in       = '0;
        chk("latency_valid", {31'd0, w_out_valid}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n < budget && !block_done) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!block_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got 0 want 1 within %0d cycles", budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) abc_blk[i] = '0;
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        for (int i = 0; i < 16; i++)
            blk2[i] = (32'(i) * 32'h11111111) ^ 32'hA5A5A5A5;

        // 1: reset
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'd0, word_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, w_out_valid}, 32'd0);
        chk("rst_done", {31'd0, block_done}, 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        reset       = 1'b1;
        mon_en      = 1'b1;
        w_out_ready = 1'b1;
        @(posedge clock);
        #1;

        // 2: "abc" block streaming at full rate
        load_block(abc_blk, 1'b1, -1);
        wait_done(200);
        @(posedge clock);
        #1;

        // 3: backpressure alternating ready
        exp_emit_cyc = 128;
        bp_mode      = 1'b1;
        load_block(abc_blk, 1'b1, -1);
        wait_done(300);
        bp_mode      = 1'b0;
        w_out_ready  = 1'b1;
        exp_emit_cyc = 64;
        @(posedge clock);
        #1;

        // 4: gap of three cycles between words 7 and 8
        load_block(abc_blk, 1'b1, 8);
        wait_done(200);
        @(posedge clock);
        #1;

        // 5: reset after W20 consumed
        load_block(abc_blk, 1'b1, -1);
        begin
            int n = 0;
            while (n < 100 && mon_idx != 21) begin
                @(posedge clock);
                #1;
                n++;
            end
            chk("reach_W20", 32'(mon_idx), 32'd21);
        end
        reset       = 1'b0;
        mon_en      = 1'b0;
        w_out_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_out_valid", {31'd0, w_out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, word_in_ready}, 32'd1);
        chk("midrst_done", {31'd0, block_done}, 32'd0);
        exp_q.delete();
        mon_idx     = 0;
        emit_cyc    = 0;
        hold_v      = 1'b0;
        done_exp    = 1'b0;
        reset       = 1'b1;
        mon_en      = 1'b1;
        w_out_ready = 1'b1;
        @(posedge clock);
        #1;
        load_block(abc_blk, 1'b1, -1);
        wait_done(200);

        // 6: back-to-back, second block starts in the done cycle
        @(posedge clock);
        #1;
        load_block(abc_blk, 1'b1, -1);
        wait_done(200);
        load_block(blk2, 1'b0, -1);
        wait_done(200);

        repeat (3) @(posedge clock);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
